// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between the decoder/mux and the SRAM slave.
interface ahb_sram_slave_if #(
  parameter int DATA_W = 32
);
  logic              HSEL;
  logic [31:0]       HADDR;
  logic              HWRITE;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic [1:0]        HRESP;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: lane-strobed sub-word writes, two-cycle ERROR response and
// optional wait states built when AHB_SRAM_WAITSTATE_EN is defined.
module ahb_sram_slave #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic             HCLK,
  input logic             HRESET,
  ahb_sram_slave_if.slave bus
);
  localparam int               NB       = DATA_W / 8;
  localparam int               OFF      = $clog2(NB);
  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [2:0]       OFF_SZ   = 3'(OFF);
  localparam logic [OFF-1:0]   OFF_ONES = '1;

`ifdef AHB_SRAM_WAITSTATE_EN
  typedef enum logic [2:0] {IDLE = 3'd0, WAIT = 3'd1, XFER = 3'd2, ERR1 = 3'd3, ERR2 = 3'd4} state_e;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  logic [3:0] cnt_q, cnt_d;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, XFER = 3'd2, ERR1 = 3'd3, ERR2 = 3'd4} state_e;
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_s, idx_q;
  logic [OFF-1:0]    off_q;
  logic [2:0]        size_q;
  logic              write_q, valid_q;
  logic              hreadyout_q, rd_phase_q;
  logic [1:0]        hresp_q;
  logic              acc_state_s, accept_s, err_s, wr_d_s, wait_d_s, mem_we_s;
  logic [NB-1:0]     strb_s;
  logic              unused_s;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign idx_s       = bus.HADDR[OFF+IDX_W-1:OFF];
  assign acc_state_s = (state_q == IDLE) || (state_q == XFER) || (state_q == ERR2);
  assign accept_s    = bus.HSEL && bus.HREADY && bus.HTRANS[1] && acc_state_s;
  // The index is sliced to exactly log2(DEPTH) bits, so it can never reach DEPTH.
  assign err_s       = (bus.HSIZE > OFF_SZ) ||
                       (|(bus.HADDR[OFF-1:0] & ~(OFF_ONES << bus.HSIZE)));
  assign wr_d_s      = accept_s ? bus.HWRITE : write_q;
  assign mem_we_s    = (state_q == XFER) && valid_q && write_q;
  assign unused_s    = ^{bus.HBURST, bus.HADDR};

`ifdef AHB_SRAM_WAITSTATE_EN
  assign wait_d_s = (state_d == WAIT);
`else
  assign wait_d_s = 1'b0;
`endif

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = rd_phase_q ? mem_q[idx_q] : '0;

  // Next-state decode
  always_comb begin
    state_d = state_q;
`ifdef AHB_SRAM_WAITSTATE_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE, XFER, ERR2: begin
        if (accept_s) begin
          if (err_s) begin
            state_d = ERR1;
`ifdef AHB_SRAM_WAITSTATE_EN
          end else if (WAIT_LD != 4'd0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LD;
`endif
          end else begin
            state_d = XFER;
          end
        end else begin
          state_d = IDLE;
        end
      end
`ifdef AHB_SRAM_WAITSTATE_EN
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = XFER;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
`endif
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  // Byte lanes covered by the registered offset and size
  always_comb begin
    strb_s = '0;
    for (int b = 0; b < NB; b++) begin
      if ((32'(b) >= 32'(off_q)) && (32'(b) < 32'(off_q) + (32'd1 << size_q))) begin
        strb_s[b] = 1'b1;
      end else begin
        strb_s[b] = 1'b0;
      end
    end
  end

  // State and registered bus outputs
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
      rd_phase_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= !(wait_d_s || (state_d == ERR1));
      hresp_q     <= ((state_d == ERR1) || (state_d == ERR2)) ? 2'b01 : 2'b00;
      rd_phase_q  <= (wait_d_s || (state_d == XFER)) && !wr_d_s;
    end
  end

  // Address-phase capture
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (accept_s) begin
      idx_q   <= idx_s;
      off_q   <= bus.HADDR[OFF-1:0];
      size_q  <= bus.HSIZE;
      write_q <= bus.HWRITE;
      valid_q <= !err_s;
    end else if (acc_state_s) begin
      valid_q <= 1'b0;
    end
  end

`ifdef AHB_SRAM_WAITSTATE_EN
  // Wait-state counter
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Storage array; contents survive reset
  always_ff @(posedge HCLK) begin
    if (mem_we_s) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_s[b]) begin
          mem_q[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: directed vector table, reset-abort
// sequences and randomized pipelined traffic against a byte-level memory model.
module tb_ahb_sram_slave;
`ifdef AHB_SRAM_WAITSTATE_EN
  localparam int WS = 2;
`else
  localparam int WS = 0;
`endif

  logic HCLK = 1'b0;
  logic HRESET;
  int   checks = 0;
  int   errors = 0;

  ahb_sram_slave_if #(.DATA_W(32)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_sram_slave #(.DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        q[$];
  vec_t        idle_v;
  vec_t        tbl[22];
  logic [31:0] ref_mem[1024];

  function automatic vec_t mk(logic sel, logic [1:0] tr, logic wr, logic [2:0] sz,
                              logic [31:0] a, logic [31:0] wd, logic chk, logic e,
                              logic [31:0] rd);
    vec_t v;
    v.sel = sel; v.trans = tr; v.wr = wr; v.size = sz; v.addr = a; v.wdata = wd;
    v.chk = chk; v.exp_err = e; v.exp_rdata = rd;
    return v;
  endfunction

  function automatic logic ref_err(logic [2:0] sz, logic [31:0] a);
    if (sz > 3'd2) return 1'b1;
    return (a % (32'd1 << sz)) != 32'd0;
  endfunction

  function automatic int ref_idx(logic [31:0] a);
    return int'((a >> 2) & 32'd1023);
  endfunction

  // Byte-addressed write: each byte lands on the lane matching its address.
  task automatic ref_write(vec_t v);
    logic [31:0] ba;
    for (int b = 0; b < (1 << v.size); b++) begin
      ba = v.addr + 32'(b);
      ref_mem[ref_idx(ba)][8*int'(ba[1:0]) +: 8] = v.wdata[8*int'(ba[1:0]) +: 8];
    end
  endtask

  task automatic check3(string name, logic r, logic [1:0] s, logic [31:0] d,
                        logic er, logic [1:0] es, logic [31:0] ed);
    checks++;
    if (r !== er || s !== es || d !== ed) begin
      errors++;
      $display("FAIL %s: got ready=%0b resp=%b rdata=%h, want ready=%0b resp=%b rdata=%h",
               name, r, s, d, er, es, ed);
    end
  endtask

  task automatic drive_addr(vec_t v);
    bus.HSEL   = v.sel;
    bus.HTRANS = v.trans;
    bus.HWRITE = v.wr;
    bus.HSIZE  = v.size;
    bus.HADDR  = v.addr;
    bus.HBURST = 3'd0;
  endtask

  // Pipelined master: issues the queue back to back, checks every cycle.
  task automatic run_queue();
    vec_t        ap, dp;
    logic        live, rdy, er;
    logic [1:0]  rsp, es;
    logic [31:0] rd, ed;
    int          cyc;
    live = 1'b0; cyc = 0; dp = idle_v;
    while (q.size() > 0 || live) begin
      if (q.size() > 0) ap = q.pop_front();
      else ap = idle_v;
      drive_addr(ap);
      forever begin
        @(negedge HCLK);
        rdy = bus.HREADYOUT; rsp = bus.HRESP; rd = bus.HRDATA;
        if (!live) begin
          er = 1'b1; es = 2'b00; ed = 32'd0;
        end else if (ref_err(dp.size, dp.addr)) begin
          er = (cyc > 0); es = 2'b01; ed = 32'd0;
        end else begin
          er = (cyc >= WS); es = 2'b00;
          ed = dp.wr ? 32'd0 : ref_mem[ref_idx(dp.addr)];
        end
        check3("cycle", rdy, rsp, rd, er, es, ed);
        @(posedge HCLK);
        if (rdy === 1'b1) begin
          if (live) begin
            if (!ref_err(dp.size, dp.addr) && dp.wr) ref_write(dp);
            if (dp.chk) begin
              checks++;
              if (rsp !== {1'b0, dp.exp_err} || rd !== dp.exp_rdata) begin
                errors++;
                $display("FAIL vector addr=%h: got resp=%b rdata=%h, want resp=%b rdata=%h",
                         dp.addr, rsp, rd, {1'b0, dp.exp_err}, dp.exp_rdata);
              end
            end
          end
          dp = ap; live = ap.sel && ap.trans[1]; cyc = 0;
          #1;
          bus.HWDATA = dp.wdata;
          break;
        end
        cyc++;
        if (cyc > WS + 4) begin
          checks++; errors++;
          $display("FAIL timeout: HREADYOUT stuck low, got %0d cycles, want at most %0d", cyc, WS + 1);
          live = 1'b0; q.delete();
          #1;
          break;
        end
      end
    end
  endtask

  initial begin
    vec_t v;
    idle_v = mk(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    HRESET = 1'b1;
    drive_addr(idle_v);
    bus.HWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check3("reset", bus.HREADYOUT, bus.HRESP, bus.HRDATA, 1'b1, 2'b00, 32'h0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    tbl[0]  = mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    tbl[1]  = mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h10,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF);
    tbl[2]  = mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h20,   32'h11223344, 1'b1, 1'b0, 32'h0);
    tbl[3]  = mk(1'b1, 2'b10, 1'b1, 3'd0, 32'h21,   32'h0000AA00, 1'b1, 1'b0, 32'h0);
    tbl[4]  = mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h20,   32'h0,        1'b1, 1'b0, 32'h1122AA44);
    tbl[5]  = mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h40,   32'h55AA55AA, 1'b1, 1'b0, 32'h0);
    tbl[6]  = mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h40,   32'h0,        1'b1, 1'b0, 32'h55AA55AA);
    tbl[7]  = mk(1'b1, 2'b10, 1'b1, 3'd3, 32'h20,   32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
    tbl[8]  = mk(1'b1, 2'b10, 1'b1, 3'd1, 32'h23,   32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
    tbl[9]  = mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h20,   32'h0,        1'b1, 1'b0, 32'h1122AA44);
    tbl[10] = mk(1'b1, 2'b00, 1'b1, 3'd2, 32'h20,   32'h0,        1'b0, 1'b0, 32'h0);
    tbl[11] = mk(1'b1, 2'b10, 1'b1, 3'd1, 32'h22,   32'hBEEF0000, 1'b1, 1'b0, 32'h0);
    tbl[12] = mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h20,   32'h0,        1'b1, 1'b0, 32'hBEEFAA44);
    tbl[13] = mk(1'b0, 2'b10, 1'b1, 3'd2, 32'h20,   32'h0,        1'b0, 1'b0, 32'h0);
    tbl[14] = mk(1'b1, 2'b10, 1'b0, 3'd0, 32'h13,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF);
    tbl[15] = mk(1'b1, 2'b01, 1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 1'b0, 32'h0);
    tbl[16] = mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h0,    32'h01020304, 1'b1, 1'b0, 32'h0);
    tbl[17] = mk(1'b1, 2'b10, 1'b1, 3'd2, 32'hFFC,  32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
    tbl[18] = mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h1000, 32'h0,        1'b1, 1'b0, 32'h01020304);
    tbl[19] = mk(1'b1, 2'b10, 1'b0, 3'd2, 32'hFFC,  32'h0,        1'b1, 1'b0, 32'hCAFEF00D);
    tbl[20] = mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h22,   32'h0,        1'b1, 1'b1, 32'h0);
    tbl[21] = mk(1'b1, 2'b11, 1'b0, 3'd1, 32'h12,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF);
    for (int i = 0; i < 22; i++) q.push_back(tbl[i]);
    run_queue();

    // Reset in the middle of a read data phase
    drive_addr(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0));
    @(posedge HCLK); #1;
    drive_addr(idle_v);
    check3("rst_rd_before", bus.HREADYOUT, bus.HRESP, bus.HRDATA, (WS == 0), 2'b00, 32'h55AA55AA);
    #2; HRESET = 1'b1; #1;
    check3("rst_rd_abort", bus.HREADYOUT, bus.HRESP, bus.HRDATA, 1'b1, 2'b00, 32'h0);
    @(negedge HCLK); HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Reset before a write data phase completes: the write must be lost
    drive_addr(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0));
    @(posedge HCLK); #1;
    bus.HWDATA = 32'h77777777;
    drive_addr(idle_v);
    check3("rst_wr_before", bus.HREADYOUT, bus.HRESP, bus.HRDATA, (WS == 0), 2'b00, 32'h0);
    #2; HRESET = 1'b1; #1;
    check3("rst_wr_abort", bus.HREADYOUT, bus.HRESP, bus.HRDATA, 1'b1, 2'b00, 32'h0);
    @(negedge HCLK); HRESET = 1'b0;
    @(posedge HCLK); #1;
    q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 1'b0, 32'h55AA55AA));
    run_queue();

    // Randomized traffic over a small initialised window
    for (int i = 0; i < 16; i++)
      q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h100 + 32'(4 * i), $urandom(), 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < 300; i++) begin
      v = mk($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 3)),
             (32'h100 + 32'($urandom_range(0, 63))) | (32'($urandom_range(0, 1)) << 20),
             $urandom(), 1'b0, 1'b0, 32'h0);
      q.push_back(v);
    end
    run_queue();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
